// File: rtl/bsram_host_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : bsram_host_arbiter
// Purpose  : Shares the cartridge BSRAM port between the mapper (always wins,
//            zero latency) and a host save/load channel that uses idle gaps.
// Option   : BSRAM_DIRTY_EN adds the dirty / dirty_clr mapper-write tracker.
// Revision : 1.0 - initial release
// ============================================================================
module bsram_host_arbiter #(
    parameter int GAP_CYC   = 4,
    parameter int ACC_CYC   = 3,
    parameter int RETRY_MAX = 255
) (
    input  logic        mclk,
    input  logic        rst_n,
    input  logic [19:0] map_addr,
    input  logic [7:0]  map_d,
    input  logic        map_ce_n,
    input  logic        map_oe_n,
    input  logic        map_we_n,
    output logic [7:0]  map_q,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [19:0] host_addr,
    input  logic [7:0]  host_wdata,
    output logic [7:0]  host_rdata,
    output logic        host_ack,
    output logic        host_err,
    output logic        busy,
    output logic [19:0] bsram_addr,
    output logic [7:0]  bsram_d,
    input  logic [7:0]  bsram_q,
    output logic        bsram_ce_n,
    output logic        bsram_oe_n,
    output logic        bsram_we_n
`ifdef BSRAM_DIRTY_EN
    ,
    output logic        dirty,
    input  logic        dirty_clr
`endif
);

    localparam logic [3:0] GAP_LAST  = 4'(GAP_CYC - 1);
    localparam logic [2:0] ACC_LAST  = 3'(ACC_CYC - 1);
    localparam logic [7:0] RETRY_LIM = 8'(RETRY_MAX);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GAP    = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  gap_q, gap_d;
    logic [2:0]  acc_q, acc_d;
    logic [7:0]  retry_q, retry_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [19:0] hold_addr_q;
    logic [7:0]  hold_d_q;

    logic        w_map_sel;
    logic        w_host_drive;

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            gap_q       <= '0;
            acc_q       <= '0;
            retry_q     <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            hold_addr_q <= '0;
            hold_d_q    <= '0;
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            acc_q       <= acc_d;
            retry_q     <= retry_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            hold_addr_q <= bsram_addr;
            hold_d_q    <= bsram_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        acc_d   = acc_q;
        retry_d = retry_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (host_req) begin
                    state_d = S_GAP;
                    gap_d   = '0;
                end
            end
            S_GAP: begin
                if (!map_ce_n) begin
                    gap_d = '0;
                end else if (gap_q == GAP_LAST) begin
                    state_d = S_ACCESS;
                    acc_d   = '0;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            S_ACCESS: begin
                // A mapper cycle always aborts; a write is then replayed in full.
                if (!map_ce_n) begin
                    state_d = S_GAP;
                    gap_d   = '0;
                    if (retry_q != 8'hFF) begin
                        retry_d = retry_q + 8'd1;
                    end
                end else if (acc_q == ACC_LAST) begin
                    if (!host_we) begin
                        rdata_d = bsram_q;
                    end
                    state_d = S_DONE;
                end else begin
                    acc_d = acc_q + 3'd1;
                end
            end
            default: begin
                retry_d = '0;
                state_d = S_IDLE;
            end
        endcase
        if (retry_d == RETRY_LIM) begin
            err_d = 1'b1;
        end
    end

    // Reset gates the mapper path so strobes are inactive while rst_n is low.
    assign w_map_sel    = rst_n & ~map_ce_n;
    assign w_host_drive = (state_q == S_ACCESS) & map_ce_n;

    always_comb begin
        bsram_addr = hold_addr_q;
        bsram_d    = hold_d_q;
        bsram_ce_n = 1'b1;
        bsram_oe_n = 1'b1;
        bsram_we_n = 1'b1;
        if (w_map_sel) begin
            bsram_addr = map_addr;
            bsram_d    = map_d;
            bsram_ce_n = map_ce_n;
            bsram_oe_n = map_oe_n;
            bsram_we_n = map_we_n;
        end else if (w_host_drive) begin
            bsram_addr = host_addr;
            bsram_ce_n = 1'b0;
            bsram_oe_n = host_we;
            bsram_we_n = ~host_we;
            if (host_we) begin
                bsram_d = host_wdata;
            end
        end
    end

    assign map_q      = bsram_q;
    assign host_rdata = rdata_q;
    assign host_ack   = (state_q == S_DONE);
    assign host_err   = err_q;
    assign busy       = (state_q != S_IDLE);

`ifdef BSRAM_DIRTY_EN
    logic dirty_q;

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            dirty_q <= 1'b0;
        end else if (!map_ce_n && !map_we_n) begin
            dirty_q <= 1'b1;
        end else if (dirty_clr) begin
            dirty_q <= 1'b0;
        end
    end

    assign dirty = dirty_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bsram_host_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_bsram_host_arbiter
// Purpose  : Self-checking bench for bsram_host_arbiter (RETRY_MAX set to 2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bsram_host_arbiter;

    logic        mclk = 1'b0;
    logic        rst_n = 1'b0;
    logic [19:0] map_addr = '0;
    logic [7:0]  map_d = '0;
    logic        map_ce_n = 1'b1;
    logic        map_oe_n = 1'b1;
    logic        map_we_n = 1'b1;
    logic [7:0]  map_q;
    logic        host_req = 1'b0;
    logic        host_we = 1'b0;
    logic [19:0] host_addr = '0;
    logic [7:0]  host_wdata = '0;
    logic [7:0]  host_rdata;
    logic        host_ack, host_err, busy;
    logic [19:0] bsram_addr;
    logic [7:0]  bsram_d, bsram_q;
    logic        bsram_ce_n, bsram_oe_n, bsram_we_n;
`ifdef BSRAM_DIRTY_EN
    logic        dirty;
    logic        dirty_clr = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    logic [7:0] mem [0:255];

    bsram_host_arbiter #(.GAP_CYC(4), .ACC_CYC(3), .RETRY_MAX(2)) dut (
        .mclk(mclk), .rst_n(rst_n),
        .map_addr(map_addr), .map_d(map_d), .map_ce_n(map_ce_n),
        .map_oe_n(map_oe_n), .map_we_n(map_we_n), .map_q(map_q),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_rdata(host_rdata), .host_ack(host_ack),
        .host_err(host_err), .busy(busy),
        .bsram_addr(bsram_addr), .bsram_d(bsram_d), .bsram_q(bsram_q),
        .bsram_ce_n(bsram_ce_n), .bsram_oe_n(bsram_oe_n), .bsram_we_n(bsram_we_n)
`ifdef BSRAM_DIRTY_EN
        , .dirty(dirty), .dirty_clr(dirty_clr)
`endif
    );

    always #5 mclk = ~mclk;

    // Small BSRAM model decoded on the low address byte.
    assign bsram_q = mem[bsram_addr[7:0]];
    always @(posedge mclk) begin
        if (!bsram_ce_n && !bsram_we_n) mem[bsram_addr[7:0]] <= bsram_d;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        host_req = 1'b0;
        map_ce_n = 1'b1;
        map_oe_n = 1'b1;
        map_we_n = 1'b1;
        repeat (3) @(posedge mclk);
        #1 rst_n = 1'b1;
        @(posedge mclk);
        #1;
    endtask

    // Runs one host transaction; pre_mask bit n makes the mapper read pre_addr in cycle n.
    task automatic run_host(input logic we, input logic [19:0] addr, input logic [7:0] wd,
                            input logic [63:0] pre_mask, input logic [19:0] pre_addr,
                            output int lat, output int we_cyc, output int acks,
                            output int pre_ok, output int busy_low, output int bad);
        lat = -1; we_cyc = 0; acks = 0; pre_ok = 0; busy_low = 0; bad = 0;
        host_we = we; host_addr = addr; host_wdata = wd; host_req = 1'b1;
        for (int n = 1; n < 60; n++) begin
            @(posedge mclk);
            #1;
            map_ce_n = ~pre_mask[n];
            map_oe_n = ~pre_mask[n];
            map_addr = pre_addr;
            #1;
            if (!bsram_ce_n && !bsram_we_n) begin
                we_cyc++;
                if (bsram_addr != addr || bsram_d != wd) bad++;
            end
            if (pre_mask[n] && bsram_addr == pre_addr && !bsram_ce_n && !bsram_oe_n && bsram_we_n)
                pre_ok++;
            if (!busy && lat < 0) busy_low++;
            if (host_ack) begin
                acks++;
                if (lat < 0) lat = n;
                host_req = 1'b0;
            end
            if (lat >= 0 && n >= lat + 3) break;
        end
        map_ce_n = 1'b1;
        map_oe_n = 1'b1;
    endtask

    typedef struct {
        logic        ce_n, oe_n, we_n;
        logic [19:0] addr;
        logic [7:0]  d;
        logic [2:0]  exp_strb;
        logic [19:0] exp_addr;
        logic [7:0]  exp_d;
    } vec_t;

    vec_t vecs [5];
    int lat, wec, acks, pok, bl, bad, hostacc, nb;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[8'h23] = 8'hA5;

        vecs[0] = '{1'b0, 1'b0, 1'b1, 20'h11111, 8'h22, 3'b001, 20'h11111, 8'h22};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 20'hABCDE, 8'h5A, 3'b010, 20'hABCDE, 8'h5A};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 20'h00000, 8'h00, 3'b111, 20'hABCDE, 8'h5A};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 20'hFFFFF, 8'hFF, 3'b011, 20'hFFFFF, 8'hFF};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 20'h12345, 8'h99, 3'b111, 20'hFFFFF, 8'hFF};

        // Reset state.
        #2;
        chk("rst_strobes", {29'd0, bsram_ce_n, bsram_oe_n, bsram_we_n}, 32'h7);
        chk("rst_addr_d", {4'd0, bsram_addr, bsram_d}, 32'h0);
        chk("rst_host", {20'd0, host_rdata, host_ack, host_err, busy, 1'b0}, 32'h0);
        do_reset();

        // Mapper pass-through and idle hold, table driven.
        for (int i = 0; i < 5; i++) begin
            map_ce_n = vecs[i].ce_n; map_oe_n = vecs[i].oe_n; map_we_n = vecs[i].we_n;
            map_addr = vecs[i].addr; map_d = vecs[i].d;
            #1;
            chk($sformatf("vec%0d_bus", i),
                {1'b0, bsram_ce_n, bsram_oe_n, bsram_we_n, bsram_addr, bsram_d},
                {1'b0, vecs[i].ce_n, vecs[i].exp_strb[1:0] | {2{vecs[i].ce_n}}, vecs[i].exp_addr, vecs[i].exp_d});
            chk($sformatf("vec%0d_mapq", i), {24'd0, map_q}, {24'd0, mem[vecs[i].exp_addr[7:0]]});
            @(posedge mclk);
            #1;
        end
        map_ce_n = 1'b1; map_oe_n = 1'b1; map_we_n = 1'b1;
        do_reset();

        // Idle-mapper read.
        run_host(1'b0, 20'h00123, 8'h00, 64'd0, 20'h0, lat, wec, acks, pok, bl, bad);
        chk("rd_latency", 32'(lat), 32'd8);
        chk("rd_data", {24'd0, host_rdata}, 32'hA5);
        chk("rd_no_we", 32'(wec), 32'd0);
        chk("rd_acks", 32'(acks), 32'd1);
        chk("rd_busy", 32'(bl), 32'd0);

        // Idle-mapper write.
        run_host(1'b1, 20'h7FFFF, 8'h3C, 64'd0, 20'h0, lat, wec, acks, pok, bl, bad);
        chk("wr_latency", 32'(lat), 32'd8);
        chk("wr_we_cycles", 32'(wec), 32'd3);
        chk("wr_bus_vals", 32'(bad), 32'd0);
        chk("wr_acks", 32'(acks), 32'd1);
        chk("wr_mem", {24'd0, mem[8'hFF]}, 32'h3C);

        // Preempted write on its 2nd access cycle: replay after 4 idle cycles.
        run_host(1'b1, 20'h00200, 8'h77, 64'd1 << 6, 20'h00010, lat, wec, acks, pok, bl, bad);
        chk("pre_latency", 32'(lat), 32'd14);
        chk("pre_we_cycles", 32'(wec), 32'd4);
        chk("pre_mapper_bus", 32'(pok), 32'd1);
        chk("pre_acks", 32'(acks), 32'd1);
        chk("pre_mem", {24'd0, mem[8'h00]}, 32'h77);
        chk("pre_err0", {31'd0, host_err}, 32'd0);
        // A second single abort must not reach RETRY_MAX=2 if the count was cleared.
        run_host(1'b1, 20'h00201, 8'h78, 64'd1 << 5, 20'h00011, lat, wec, acks, pok, bl, bad);
        chk("retry_cleared", {31'd0, host_err}, 32'd0);
        chk("pre2_latency", 32'(lat), 32'd13);

        // Mapper active every 3rd cycle: gap never reached.
        hostacc = 0; acks = 0; nb = 0;
        host_we = 1'b0; host_addr = 20'h00040; host_req = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge mclk);
            #1;
            map_ce_n = (n % 3 == 0) ? 1'b0 : 1'b1;
            map_oe_n = map_ce_n;
            map_addr = 20'h00050;
            #1;
            if (map_ce_n && !bsram_ce_n) hostacc++;
            if (host_ack) acks++;
            if (!busy) nb++;
        end
        chk("starve_access", 32'(hostacc), 32'd0);
        chk("starve_ack", 32'(acks), 32'd0);
        chk("starve_busy", 32'(nb), 32'd0);
        do_reset();

        // Two aborts reach RETRY_MAX=2; the second coincides with ACCESS entry.
        run_host(1'b0, 20'h00123, 8'h00, (64'd1 << 5) | (64'd1 << 10), 20'h00030,
                 lat, wec, acks, pok, bl, bad);
        chk("err_latency", 32'(lat), 32'd18);
        chk("err_aborts_seen", 32'(pok), 32'd2);
        chk("err_sticky", {31'd0, host_err}, 32'd1);
        chk("err_rdata", {24'd0, host_rdata}, 32'hA5);
        do_reset();
        chk("err_reset", {31'd0, host_err}, 32'd0);

        // Reset asserted in the middle of an access.
        host_we = 1'b0; host_addr = 20'h00123; host_req = 1'b1;
        repeat (6) @(posedge mclk);
        #2;
        chk("mid_in_access", {31'd0, bsram_ce_n}, 32'd0);
        rst_n = 1'b0;
        host_req = 1'b0;
        #1;
        chk("mid_rst_strobes", {29'd0, bsram_ce_n, bsram_oe_n, bsram_we_n}, 32'h7);
        chk("mid_rst_state", {30'd0, busy, host_ack}, 32'd0);
        repeat (2) @(posedge mclk);
        #1 rst_n = 1'b1;
        acks = 0; nb = 0;
        for (int n = 0; n < 12; n++) begin
            @(posedge mclk);
            #1;
            if (host_ack) acks++;
            if (busy) nb++;
        end
        chk("mid_no_ack", 32'(acks), 32'd0);
        chk("mid_idle", 32'(nb), 32'd0);

`ifdef BSRAM_DIRTY_EN
        chk("dirty_rst", {31'd0, dirty}, 32'd0);
        map_ce_n = 1'b0; map_we_n = 1'b0; map_addr = 20'h00060; map_d = 8'h11;
        @(posedge mclk); #1;
        map_ce_n = 1'b1; map_we_n = 1'b1;
        chk("dirty_set", {31'd0, dirty}, 32'd1);
        dirty_clr = 1'b1; map_ce_n = 1'b0; map_we_n = 1'b0;
        @(posedge mclk); #1;
        chk("dirty_clr_vs_wr", {31'd0, dirty}, 32'd1);
        map_ce_n = 1'b1; map_we_n = 1'b1;
        @(posedge mclk); #1;
        dirty_clr = 1'b0;
        chk("dirty_clr", {31'd0, dirty}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bsram_host_arbiter.md
Name: bsram_host_arbiter

Overview:
- Shares the single cartridge BSRAM port between two requesters: the active mapper's BSRAM strobes, and a host save/load channel that reads and writes backup RAM for save-file upload/download.
- Sits between the mapper output mux and the BSRAM memory.
- The mapper always has priority and is never stalled. Host accesses are slotted into mapper idle gaps and are aborted and retried if the mapper preempts them.

Parameters:
GAP_CYC, 4, consecutive mclk cycles with map_ce_n=1 required before a host access starts (1..15)
ACC_CYC, 3, mclk cycles a host access holds BSRAM strobes active; read data sampled on last cycle (1..7)
RETRY_MAX, 255, abort count at which host_err asserts (8-bit saturating)

Ports:
mclk  in  1  system master clock
rst_n  in  1  asynchronous active-low reset
map_addr  in  20  mapper BSRAM address
map_d  in  8  mapper write data
map_ce_n  in  1  mapper chip enable, active low
map_oe_n  in  1  mapper output enable, active low
map_we_n  in  1  mapper write enable, active low
map_q  out  8  read data to mapper (= bsram_q)
host_req  in  1  host access request, level; held until host_ack
host_we  in  1  1=write, 0=read; stable while host_req=1
host_addr  in  20  host byte address; stable while host_req=1
host_wdata  in  8  host write data
host_rdata  out  8  registered host read data
host_ack  out  1  one-cycle completion pulse
host_err  out  1  sticky: retry count reached RETRY_MAX
busy  out  1  host FSM not in IDLE
bsram_addr  out  20  BSRAM address
bsram_d  out  8  BSRAM write data
bsram_q  in  8  BSRAM read data
bsram_ce_n  out  1  BSRAM chip enable
bsram_oe_n  out  1  BSRAM output enable
bsram_we_n  out  1  BSRAM write enable

Behaviour:
Clock and reset:
- One clock, mclk. Reset rst_n is asynchronous and active-low.
- While rst_n=0:
  - FSM=IDLE; gap and access counters 0; retry count 0.
  - host_rdata=0, host_ack=0, host_err=0, busy=0.
  - bsram_ce_n/oe_n/we_n=1; bsram_addr=0; bsram_d=0.

Mapper path (combinational, zero latency):
- When map_ce_n=0, the bsram_* outputs equal the map_* inputs regardless of FSM state.
- map_q = bsram_q at all times.

Host FSM, states IDLE, GAP, ACCESS, DONE:
- IDLE: host_req=1 -> GAP, gap counter cleared. Otherwise, when map_ce_n=1, bsram strobes are 1 and addr/d hold the last value.
- GAP:
  - Counter increments on each cycle with map_ce_n=1 and clears to 0 on any cycle with map_ce_n=0.
  - Counter reaching GAP_CYC-1 with map_ce_n=1 -> ACCESS, access counter cleared.
- ACCESS (bsram driven from host side, provided map_ce_n=1):
  - bsram_addr=host_addr; bsram_ce_n=0.
  - Read: oe_n=0, we_n=1.
  - Write: oe_n=1, we_n=0, bsram_d=host_wdata.
  - On the cycle the counter reaches ACC_CYC-1: a read latches bsram_q into host_rdata; then -> DONE.
- Preemption: map_ce_n=0 in any ACCESS cycle:
  - The mapper takes the port that cycle.
  - Host access aborts -> GAP; retry count +1 (saturating).
  - Write abort: the write is replayed in full on retry.
  - Read abort: host_rdata is not updated.
- DONE:
  - host_ack=1 for exactly this cycle; retry count cleared; -> IDLE.
  - The host may present the next request on the cycle after the ack; it is accepted in IDLE one cycle later.
- host_err: set when the retry count reaches RETRY_MAX; cleared only by reset. The FSM keeps retrying.
- Dropping host_req before ack is illegal; the FSM completes the access anyway and still pulses host_ack.
- Latency with an idle mapper, req rise to ack: 1 (IDLE) + GAP_CYC + ACC_CYC cycles. With the defaults this is 8 cycles.
- Simultaneous map_ce_n fall and ACCESS entry: the mapper wins and the FSM counts an abort.

Optional Feature:
BSRAM_DIRTY_EN:
- Defined: adds output dirty (1 bit) and input dirty_clr (1 bit).
- dirty sets on any mclk cycle with map_ce_n=0 and map_we_n=0.
- dirty_clr=1 clears it; a simultaneous mapper write wins, leaving dirty=1.
- Reset value 0. Host writes never set dirty.
- Undefined: the ports are absent and no dirty logic is built.

Test Plan:
- Mapper idle, host read addr 0x00123 with BSRAM holding 0xA5 at 0x00123 -> host_ack 8 cycles after req; host_rdata=0xA5; bsram_we_n stays 1.
- Host write 0x3C to 0x7FFFF, mapper idle -> bsram_we_n=0 for exactly 3 cycles with addr 0x7FFFF and d 0x3C; one ack pulse.
- Mapper pulses map_ce_n=0 (read, addr 0x00010) on the 2nd ACCESS cycle of a host write -> bsram shows the mapper addr that cycle; the host write replays after 4 idle cycles with 3 full we_n cycles; ack once; retry count returns to 0.
- Mapper holds map_ce_n low every 3rd cycle -> the gap is never reached; no host ACCESS; no ack; busy=1 throughout.
- RETRY_MAX=2, two preemptions -> host_err=1 and stays 1 after the eventual ack; clears only on rst_n low.
- Assert rst_n=0 mid-ACCESS -> strobes go 1 immediately (asynchronously); no ack; busy=0; after release the host must re-request. With BSRAM_DIRTY_EN: a mapper write sets dirty=1, and dirty_clr with no concurrent write clears it.
